// File: rtl/mem_pkg.sv
// Shared types for the data memory: width codes, FSM states, access-size helper.
// Pure declarations; no latency or backpressure of its own.
package mem_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    F3_B  = 3'd0,
    F3_H  = 3'd1,
    F3_W  = 3'd2,
    F3_BU = 3'd4,
    F3_HU = 3'd5
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  // Access size in bytes from the width code; 0 marks an undefined size.
  function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'd0:    size_bytes = 3'd1;
      2'd1:    size_bytes = 3'd2;
      2'd2:    size_bytes = 3'd4;
      default: size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Load byte selection and sign/zero extension from a storage word.
// Purely combinational; no backpressure.
module dmem_align
  import mem_pkg::*;
(
  input  logic [XLEN-1:0] rdata_word_i,
  input  logic [1:0]      byte_off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] load_data_o
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata_word_i >> {byte_off_i, 3'b000};

  always_comb begin
    load_data_o = shifted;
    case (funct3_i)
      F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_BU:   load_data_o = {24'd0, shifted[7:0]};
      F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_HU:   load_data_o = {16'd0, shifted[15:0]};
      default: load_data_o = shifted;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressed RV32 data memory, one request in flight, READ_LATENCY cycles to response.
// req_ready only in IDLE; the response is held until resp_ready.
module data_mem #(
  parameter int XLEN         = 32,
  parameter int MEM_SIZE     = 4096,
  parameter int READ_LATENCY = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [2:0]      req_funct3,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            resp_fault
);
  import mem_pkg::*;

  localparam int            WORDS     = MEM_SIZE / 4;
  localparam int            AW        = $clog2(WORDS);
  localparam logic [XLEN:0] MEM_LIMIT = (XLEN+1)'(MEM_SIZE);
  localparam logic [2:0]    LAT_M1    = 3'(READ_LATENCY - 1);

  logic [XLEN-1:0] mem_q [WORDS];

  state_e          state_q;
  logic [2:0]      cnt_q;
  logic            req_ready_q;
  logic            resp_valid_q;
  logic            resp_fault_q;
  logic [XLEN-1:0] resp_data_q;

  logic            accept;
  logic [2:0]      size;
  logic            legal_f3;
  logic            misalign;
  logic            out_of_range;
  logic            fault_d;
  logic [AW-1:0]   word_idx;
  logic [XLEN-1:0] rd_word;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] resp_data_d;
  logic [3:0]      size_mask;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d;
  logic            store_en;

  assign accept = req_valid & req_ready_q;
  assign size   = size_bytes(req_funct3);

  always_comb begin
    legal_f3 = 1'b0;
    case (req_funct3)
      F3_B, F3_H, F3_W: legal_f3 = 1'b1;
      F3_BU, F3_HU:     legal_f3 = ~req_write;
      default:          legal_f3 = 1'b0;
    endcase
  end

  assign misalign = ((size == 3'd2) && req_addr[0]) ||
                    ((size == 3'd4) && (req_addr[1:0] != 2'b00));

  // One extra bit so an address near 2^32 cannot wrap past the limit check.
  assign out_of_range = ({1'b0, req_addr} + (XLEN+1)'(size)) > MEM_LIMIT;
  assign fault_d      = ~legal_f3 | misalign | out_of_range;

  assign word_idx = req_addr[AW+1:2];
  assign rd_word  = mem_q[word_idx];

  dmem_align u_align (
    .rdata_word_i (rd_word),
    .byte_off_i   (req_addr[1:0]),
    .funct3_i     (req_funct3),
    .load_data_o  (load_data)
  );

  assign resp_data_d = (req_write | fault_d) ? '0 : load_data;

  always_comb begin
    size_mask = 4'b0000;
    case (size)
      3'd1:    size_mask = 4'b0001;
      3'd2:    size_mask = 4'b0011;
      3'd4:    size_mask = 4'b1111;
      default: size_mask = 4'b0000;
    endcase
  end

  assign be_d     = size_mask << req_addr[1:0];
  assign wdata_d  = req_wdata << {req_addr[1:0], 3'b000};
  assign store_en = accept & req_write & ~fault_d & ~reset;

  // Storage is deliberately outside reset so contents survive it.
  always_ff @(posedge clock) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be_d[b]) mem_q[word_idx][8*b +: 8] <= wdata_d[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            req_ready_q  <= 1'b0;
            resp_data_q  <= resp_data_d;
            resp_fault_q <= fault_d;
            if (READ_LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
            end else begin
              state_q <= WAIT;
              cnt_q   <= LAT_M1;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 3'd1) begin
            state_q      <= RESP;
            cnt_q        <= 3'd0;
            resp_valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_fault_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: two instances (latency 1 and 3) against a byte-array reference model.
module tb_data_mem;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [2];
  logic        req_valid  [2];
  logic        req_write  [2];
  logic        resp_ready [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic [2:0]  req_funct3 [2];
  logic        req_ready  [2];
  logic        resp_valid [2];
  logic        resp_fault [2];
  logic [31:0] resp_data  [2];

  logic [7:0]  ref_mem [2][4096];
  int          n_total = 0;
  int          n_pass  = 0;

  data_mem #(.XLEN(32), .MEM_SIZE(4096), .READ_LATENCY(1)) u_dut0 (
    .clock(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .req_funct3(req_funct3[0]), .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .resp_fault(resp_fault[0])
  );

  data_mem #(.XLEN(32), .MEM_SIZE(4096), .READ_LATENCY(3)) u_dut1 (
    .clock(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .req_funct3(req_funct3[1]), .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .resp_fault(resp_fault[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Reference: byte array, size/legality/range rules, extension by arithmetic.
  task automatic model(input int d, input bit wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       output logic [31:0] exp_data, output logic exp_fault);
    int n;
    bit legal;
    bit sgn;
    longint unsigned a;
    longint v;
    a = addr;
    case (f3)
      3'd0, 3'd4: n = 1;
      3'd1, 3'd5: n = 2;
      3'd2:       n = 4;
      default:    n = 0;
    endcase
    legal     = wr ? (f3 <= 3'd2) : (n != 0);
    sgn       = (f3 == 3'd0) || (f3 == 3'd1);
    exp_fault = !legal;
    if (legal) exp_fault = ((a % n) != 0) || ((a + n) > 4096);
    exp_data = 32'd0;
    if (!exp_fault) begin
      if (wr) begin
        for (int i = 0; i < n; i++) ref_mem[d][int'(a) + i] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[d][int'(a) + i]) << (8 * i);
        if (sgn && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        exp_data = v[31:0];
      end
    end
  endtask

  task automatic txn(input int d, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [2:0] f3, input string tag,
                     output logic [31:0] data, output logic fault);
    logic [31:0] exp_data;
    logic        exp_fault;
    int          lat;
    bit          got;
    model(d, wr, addr, wdata, f3, exp_data, exp_fault);
    @(negedge clk);
    req_write[d]  = wr;
    req_addr[d]   = addr;
    req_wdata[d]  = wdata;
    req_funct3[d] = f3;
    req_valid[d]  = 1'b1;
    chk({tag, "/rdy_idle"}, 32'(req_ready[d]), 32'd1);
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = 1;
    got = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (resp_valid[d]) begin
        got = 1;
        break;
      end
      lat++;
    end
    chk({tag, "/latency"}, 32'(lat), (d == 0) ? 32'd1 : 32'd3);
    data  = resp_data[d];
    fault = resp_fault[d];
    if (got) begin
      chk({tag, "/rdy_busy"}, 32'(req_ready[d]), 32'd0);
      chk({tag, "/data"}, data, exp_data);
      chk({tag, "/fault"}, 32'(fault), 32'(exp_fault));
    end
    resp_ready[d] = 1'b1;
    @(posedge clk);
    #1 resp_ready[d] = 1'b0;
  endtask

  initial begin
    logic [31:0] data;
    logic        fault;
    logic [31:0] ed;
    logic        ef;
    logic [31:0] held;
    bit          seen;
    int          sel;

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0; resp_ready[d] = 1'b0;
      req_addr[d] = '0; req_wdata[d] = '0; req_funct3[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst/req_ready", 32'(req_ready[d]), 32'd1);
      chk("rst/resp_valid", 32'(resp_valid[d]), 32'd0);
      chk("rst/resp_data", resp_data[d], 32'd0);
      chk("rst/resp_fault", 32'(resp_fault[d]), 32'd0);
    end

    for (int d = 0; d < 2; d++) begin
      for (int w = 0; w < 64; w++) txn(d, 1'b1, 32'(4 * w), $urandom, 3'd2, "init_lo", data, fault);
      for (int w = 0; w < 4; w++) txn(d, 1'b1, 32'(4080 + 4 * w), $urandom, 3'd2, "init_hi", data, fault);
    end

    txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2, "sw10", data, fault);
    chk("sw10/data0", data, 32'd0);
    txn(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw10", data, fault);
    chk("lw10/const", data, 32'hDEADBEEF);
    chk("lw10/nofault", 32'(fault), 32'd0);
    txn(0, 1'b0, 32'h13, 32'h0, 3'd0, "lb13", data, fault);
    chk("lb13/const", data, 32'hFFFFFFDE);
    txn(0, 1'b0, 32'h13, 32'h0, 3'd4, "lbu13", data, fault);
    chk("lbu13/const", data, 32'h000000DE);
    txn(0, 1'b0, 32'h12, 32'h0, 3'd1, "lh12", data, fault);
    chk("lh12/const", data, 32'hFFFFDEAD);
    txn(0, 1'b0, 32'h10, 32'h0, 3'd5, "lhu10", data, fault);
    chk("lhu10/const", data, 32'h0000BEEF);
    txn(0, 1'b1, 32'h11, 32'hFFFFFF55, 3'd0, "sb11", data, fault);
    txn(0, 1'b0, 32'h10, 32'h0, 3'd2, "lw10b", data, fault);
    chk("lw10b/const", data, 32'hDEAD55EF);

    txn(0, 1'b1, 32'h20, 32'hCAFEF00D, 3'd2, "sw20", data, fault);
    txn(0, 1'b0, 32'h12, 32'h0, 3'd2, "f_lw12", data, fault);
    chk("f_lw12/fault", 32'(fault), 32'd1);
    chk("f_lw12/data", data, 32'd0);
    txn(0, 1'b1, 32'h21, 32'h00001234, 3'd1, "f_sh21", data, fault);
    chk("f_sh21/fault", 32'(fault), 32'd1);
    txn(0, 1'b0, 32'd4094, 32'h0, 3'd2, "f_lwtop", data, fault);
    chk("f_lwtop/fault", 32'(fault), 32'd1);
    txn(0, 1'b0, 32'h0, 32'h0, 3'd3, "f_f3_3", data, fault);
    chk("f_f3_3/fault", 32'(fault), 32'd1);
    chk("f_f3_3/data", data, 32'd0);
    txn(0, 1'b0, 32'hFFFFFFFC, 32'h0, 3'd2, "f_wrap", data, fault);
    chk("f_wrap/fault", 32'(fault), 32'd1);
    txn(0, 1'b1, 32'h24, 32'h0, 3'd4, "f_sbu", data, fault);
    chk("f_sbu/fault", 32'(fault), 32'd1);
    txn(0, 1'b0, 32'd4092, 32'h0, 3'd2, "lw_last", data, fault);
    chk("lw_last/fault", 32'(fault), 32'd0);
    txn(0, 1'b0, 32'h20, 32'h0, 3'd2, "lw20", data, fault);
    chk("lw20/const", data, 32'hCAFEF00D);

    // Latency-3 instance with a stalled consumer.
    txn(1, 1'b1, 32'h80, 32'hA1B2C3D4, 3'd2, "sw80", data, fault);
    @(negedge clk);
    req_write[1] = 1'b0; req_addr[1] = 32'h80; req_funct3[1] = 3'd2; req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("l3/early_valid", 32'(resp_valid[1]), 32'd0);
      chk("l3/early_rdy", 32'(req_ready[1]), 32'd0);
    end
    @(negedge clk);
    chk("l3/valid_at3", 32'(resp_valid[1]), 32'd1);
    chk("l3/data", resp_data[1], 32'hA1B2C3D4);
    held = resp_data[1];
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("l3/hold_valid", 32'(resp_valid[1]), 32'd1);
      chk("l3/hold_data", resp_data[1], 32'hA1B2C3D4);
      chk("l3/hold_rdy", 32'(req_ready[1]), 32'd0);
    end
    resp_ready[1] = 1'b1;
    @(posedge clk);
    #1 resp_ready[1] = 1'b0;
    @(negedge clk);
    chk("l3/idle_rdy", 32'(req_ready[1]), 32'd1);
    chk("l3/idle_valid", 32'(resp_valid[1]), 32'd0);
    chk("l3/held_const", held, 32'hA1B2C3D4);

    // Reset while in WAIT after an accepted store.
    model(1, 1'b1, 32'h40, 32'h12345678, 3'd2, ed, ef);
    @(negedge clk);
    req_write[1] = 1'b1; req_addr[1] = 32'h40; req_wdata[1] = 32'h12345678;
    req_funct3[1] = 3'd2; req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    reset[1] = 1'b1;
    @(negedge clk);
    reset[1] = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen |= resp_valid[1];
    end
    chk("rstw/no_resp", 32'(seen), 32'd0);
    chk("rstw/rdy", 32'(req_ready[1]), 32'd1);
    txn(1, 1'b0, 32'h40, 32'h0, 3'd2, "rstw_lw40", data, fault);
    chk("rstw_lw40/const", data, 32'h12345678);

    for (int i = 0; i < 150; i++) begin
      for (int d = 0; d < 2; d++) begin
        sel = $urandom_range(0, 9);
        if (sel < 7)      ed = 32'($urandom_range(0, 255));
        else if (sel < 9) ed = 32'($urandom_range(4080, 4111));
        else              ed = $urandom | 32'h1000_0000;
        txn(d, 1'($urandom_range(0, 1)), ed, $urandom, 3'($urandom_range(0, 7)), "rand", data, fault);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
